seq_muldiv_unit: RTL and testbench



---
 rtl/seq_muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_seq_muldiv_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: multi-cycle multiply/divide unit for the 8-bit datapath.
// Operands come from the register bank read ports (rd1 -> a, rd2 -> b).
// The result goes back through the bank write port (wd3/wa3/we3).
// The start/busy/done handshake lets the control FSM stall while an operation runs.
//
// Optional build macro SEQ_MULDIV_SIGNED_EN adds the sgn input for two's
// complement operation. Magnitudes are taken when the operands are latched.
// The sign is fixed up combinationally in WB, so latency does not change.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; operands, op and dest latched on start
// RUN    | one shift-add / restoring-divide iteration per cycle, WIDTH cycles
// WB     | single write-back cycle: done=1, we3=1 unless dest==0
module seq_muldiv_unit #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SEQ_MULDIV_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    dest,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] wd3,
  output logic [AW-1:0]    wa3,
  output logic             we3,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  // acc_q: upper product half (MUL) or partial remainder (DIV)
  // lo_q:  multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] araw_q;
  logic [1:0]       op_q;
  logic [AW-1:0]    dest_q;
  logic             dz_pend_q;
  logic [WIDTH-1:0] wd3_q;
  logic [AW-1:0]    wa3_q;
  logic             dz_q;
`ifdef SEQ_MULDIV_SIGNED_EN
  logic             neg_q;
  logic             rneg_q;
  logic             a_neg;
  logic             b_neg;
`endif

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   result;

  // operand magnitudes taken at latch time
  always_comb begin
    a_mag = a;
    b_mag = b;
`ifdef SEQ_MULDIV_SIGNED_EN
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    if (a_neg) a_mag = ~a + WIDTH'(1);
    if (b_neg) b_mag = ~b + WIDTH'(1);
`endif
  end

  // single-iteration datapath for both shift-add multiply and restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_rem   = WIDTH'(div_shift - {1'b0, opb_q});
  end

  // result selection with sign correction; divide-by-zero overrides the divide results
  always_comb begin
    prod = {acc_q, lo_q};
    quot = lo_q;
    rem  = acc_q;
`ifdef SEQ_MULDIV_SIGNED_EN
    if (neg_q) begin
      prod = ~prod + (2*WIDTH)'(1);
      quot = ~quot + WIDTH'(1);
    end
    if (rneg_q) rem = ~rem + WIDTH'(1);
`endif
    result = '0;
    case (op_q)
      2'b00:   result = prod[WIDTH-1:0];
      2'b01:   result = prod[2*WIDTH-1:WIDTH];
      2'b10:   result = dz_pend_q ? '1 : quot;
      default: result = dz_pend_q ? araw_q : rem;
    endcase
  end

  // control FSM and iteration registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      araw_q    <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      dz_pend_q <= 1'b0;
`ifdef SEQ_MULDIV_SIGNED_EN
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q  <= '0;
            lo_q   <= a_mag;
            opb_q  <= b_mag;
            araw_q <= a;
            op_q   <= op;
            dest_q <= dest;
            cnt_q  <= CW'(WIDTH);
`ifdef SEQ_MULDIV_SIGNED_EN
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
`endif
            if (op[1] && (b == '0)) begin
              dz_pend_q <= 1'b1;
              state_q   <= S_WB;
            end else begin
              dz_pend_q <= 1'b0;
              state_q   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (op_q[1]) begin
            acc_q <= div_ge ? div_rem : div_shift[WIDTH-1:0];
            lo_q  <= {lo_q[WIDTH-2:0], div_ge};
          end else begin
            acc_q <= mul_sum[WIDTH:1];
            lo_q  <= {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(1)) state_q <= S_WB;
        end
        S_WB: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // write-back data, address and dz are held after WB
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd3_q <= '0;
      wa3_q <= '0;
      dz_q  <= 1'b0;
    end else if (state_q == S_WB) begin
      wd3_q <= result;
      wa3_q <= dest_q;
      dz_q  <= dz_pend_q;
    end
  end

  // handshake and write-port outputs decoded from state
  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_WB);
    done = (state_q == S_WB);
    we3  = done && (dest_q != '0);
    wd3  = done ? result : wd3_q;
    wa3  = done ? dest_q : wa3_q;
    dz   = done ? dz_pend_q : dz_q;
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Bench for seq_muldiv_unit (unsigned build). The expected results come from plain integer arithmetic.
module tb_seq_muldiv_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] dest;
  logic       busy;
  logic       done;
  logic [7:0] wd3;
  logic [2:0] wa3;
  logic       we3;
  logic       dz;

  int n_checks = 0;
  int n_pass   = 0;

  seq_muldiv_unit #(.WIDTH(8), .AW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .dest  (dest),
    .busy  (busy),
    .done  (done),
    .wd3   (wd3),
    .wa3   (wa3),
    .we3   (we3),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // returns {dz, data}
  function automatic logic [8:0] ref_op(input int ia, input int ib, input int iop);
    int p;
    p = ia * ib;
    case (iop)
      0:       return {1'b0, 8'(p % 256)};
      1:       return {1'b0, 8'(p / 256)};
      2:       return (ib == 0) ? {1'b1, 8'hFF} : {1'b0, 8'(ia / ib)};
      default: return (ib == 0) ? {1'b1, 8'(ia)} : {1'b0, 8'(ia % ib)};
    endcase
  endfunction

  // called at the start of a cycle with the DUT idle; returns one cycle after WB
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop,
                       input logic [2:0] idest, input bit noise);
    logic [8:0] exp;
    int         exp_wb;
    int         k;
    bit         busy_ok;
    exp    = ref_op(int'(ia), int'(ib), int'(iop));
    exp_wb = (iop[1] && ib == 8'd0) ? 1 : 9;
    a = ia; b = ib; op = iop; dest = idest; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    k       = 1;
    busy_ok = 1'b1;
    while (k <= 20 && !done) begin
      if (!busy || we3) busy_ok = 1'b0;
      if (noise) begin
        a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); dest = 3'($urandom);
        start = (k == 3 || k == 5);
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk("latency", 32'(k), 32'(exp_wb));
    chk("busy_run", 32'(busy_ok), 32'd1);
    chk("wb_busy", 32'(busy), 32'd1);
    chk("wb_done", 32'(done), 32'd1);
    chk("wb_we3", 32'(we3), 32'(idest != 3'd0));
    chk("wb_wa3", 32'(wa3), 32'(idest));
    chk("wb_wd3", 32'(wd3), 32'(exp[7:0]));
    chk("wb_dz", 32'(dz), 32'(exp[8]));
    @(posedge clk); #1;
    chk("post_done", 32'(done), 32'd0);
    chk("post_we3", 32'(we3), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("hold_wd3", 32'(wd3), 32'(exp[7:0]));
    chk("hold_wa3", 32'(wa3), 32'(idest));
    chk("hold_dz", 32'(dz), 32'(exp[8]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    rst = 1'b0; start = 1'b0; op = 2'b00; a = 8'd0; b = 8'd0; dest = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_wd3", 32'(wd3), 32'd0);
    chk("rst_wa3", 32'(wa3), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op(8'd13,  8'd11,  2'b00, 3'd3, 1'b0);
    do_op(8'd200, 8'd200, 2'b01, 3'd1, 1'b0);
    do_op(8'd200, 8'd200, 2'b00, 3'd2, 1'b0);
    do_op(8'd100, 8'd7,   2'b10, 3'd4, 1'b0);
    do_op(8'd100, 8'd7,   2'b11, 3'd6, 1'b0);
    do_op(8'h55,  8'd0,   2'b10, 3'd5, 1'b0);
    do_op(8'h55,  8'd0,   2'b11, 3'd5, 1'b0);
    do_op(8'd77,  8'd3,   2'b00, 3'd7, 1'b1);
    do_op(8'd250, 8'd9,   2'b11, 3'd0, 1'b1);
    do_op(8'd255, 8'd255, 2'b01, 3'd2, 1'b0);
    do_op(8'd255, 8'd1,   2'b10, 3'd3, 1'b0);
    do_op(8'd5,   8'd200, 2'b11, 3'd1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      do_op(8'($urandom_range(0, 255)), rb, 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    // abort in cycle 4 after leaving dz set by a divide-by-zero
    do_op(8'h33, 8'd0, 2'b10, 3'd2, 1'b0);
    a = 8'd13; b = 8'd11; op = 2'b00; dest = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_we3", 32'(we3), 32'd0);
    chk("abort_dz", 32'(dz), 32'd0);
    chk("abort_wd3", 32'(wd3), 32'd0);
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (we3 || done || busy) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_wb", 32'(bad), 32'd0);
    do_op(8'd100, 8'd7, 2'b10, 3'd4, 1'b0);
    do_op(8'd13, 8'd11, 2'b00, 3'd3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
